// File: rtl/norm_pkg.sv
// Shared types and constants for the leading-zero normalizer.
package norm_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_SHW   = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Result reported for an all-zero input word.
  localparam logic [DEF_WIDTH-1:0] ZERO_DATA  = '0;
  localparam logic [DEF_SHW-1:0]   ZERO_SHAMT = '0;
  localparam logic                 ZERO_FLAG  = 1'b1;

endpackage

// File: rtl/norm_stage.sv
// One binary-search step: shift left by 2^k when the top 2^k bits are zero.
module norm_stage
  import norm_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SHW   = DEF_SHW
) (
  input  logic [WIDTH-1:0] work_i,
  input  logic [SHW-1:0]   k_i,
  output logic [WIDTH-1:0] work_o,
  output logic             hit_o
);

  logic [SHW:0]     step_c;
  logic [WIDTH-1:0] mask_c;

  always_comb begin
    step_c = (SHW+1)'(1) << k_i;
    mask_c = ~({WIDTH{1'b1}} >> step_c);
    hit_o  = (work_i & mask_c) == '0;
    work_o = hit_o ? (work_i << step_c) : work_i;
  end

endmodule

// File: rtl/leading_zero_normalizer.sv
// Iterative left-normalizer: one binary-search step per clock, results held
// until the downstream consumer takes them.
module leading_zero_normalizer
  import norm_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SHW   = DEF_SHW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SHW-1:0]   out_shamt,
  output logic             out_zero,
  output logic             out_valid,
  input  logic             out_ready
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   shamt_q, shamt_d;
  logic [SHW-1:0]   step_q, step_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SHW-1:0]   out_shamt_q, out_shamt_d;
  logic             out_zero_q, out_zero_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] stage_work;
  logic             stage_hit;

  norm_stage #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_stage (
    .work_i (work_q),
    .k_i    (step_q),
    .work_o (stage_work),
    .hit_o  (stage_hit)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      work_q      <= '0;
      shamt_q     <= '0;
      step_q      <= '0;
      zero_q      <= 1'b0;
      out_data_q  <= '0;
      out_shamt_q <= '0;
      out_zero_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      shamt_q     <= shamt_d;
      step_q      <= step_d;
      zero_q      <= zero_d;
      out_data_q  <= out_data_d;
      out_shamt_q <= out_shamt_d;
      out_zero_q  <= out_zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    shamt_d     = shamt_q;
    step_d      = step_q;
    zero_d      = zero_q;
    out_data_d  = out_data_q;
    out_shamt_d = out_shamt_q;
    out_zero_d  = out_zero_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_data;
          shamt_d = '0;
          step_d  = SHW'(SHW - 1);
          zero_d  = (in_data == '0);
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        work_d          = stage_work;
        shamt_d[step_q] = stage_hit;
        if (step_q == '0) begin
          // An all-zero word would search to all ones; report the zero result.
          out_valid_d = 1'b1;
          out_zero_d  = zero_q;
          out_data_d  = zero_q ? WIDTH'(ZERO_DATA) : stage_work;
          out_shamt_d = zero_q ? SHW'(ZERO_SHAMT) : shamt_d;
          state_d     = DONE;
        end else begin
          step_d = step_q - SHW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_data  = out_data_q;
  assign out_shamt = out_shamt_q;
  assign out_zero  = out_zero_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_leading_zero_normalizer.sv
// Directed bench for leading_zero_normalizer with an exhaustive 8-bit sweep.
module tb_leading_zero_normalizer;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic [2:0] out_shamt;
  logic       out_zero;
  logic       out_valid;
  logic       out_ready;

  int n_checks = 0;
  int n_pass   = 0;

  leading_zero_normalizer #(
    .WIDTH (8),
    .SHW   (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_shamt (out_shamt),
    .out_zero  (out_zero),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Send one word, check latency, wait hold cycles with out_ready low, consume.
  task automatic xfer(input logic [7:0] d, input int hold,
                      output logic [7:0] od, output logic [2:0] os, output logic oz);
    int cyc;
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 1);
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = ~d;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!out_valid && cyc < 12);
    check("latency", 32'(cyc), 4);
    od = out_data;
    os = out_shamt;
    oz = out_zero;
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("consumed_valid", 32'(out_valid), 0);
    check("in_ready_after", 32'(in_ready), 1);
  endtask

  initial begin
    logic [7:0] od;
    logic [2:0] os;
    logic       oz;
    int         cyc;
    int         lz;
    bit         found;
    logic [7:0] v;

    rst_n     = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Reset and idle behaviour.
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_shamt", 32'(out_shamt), 0);
    check("rst_out_zero", 32'(out_zero), 0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("idle_no_output", 32'(out_valid), 0);
    end
    out_ready = 1'b0;

    // Basic and extreme words.
    xfer(8'h13, 0, od, os, oz);
    check("h13_data", 32'(od), 32'h98);
    check("h13_shamt", 32'(os), 3);
    check("h13_zero", 32'(oz), 0);
    xfer(8'h80, 0, od, os, oz);
    check("h80_data", 32'(od), 32'h80);
    check("h80_shamt", 32'(os), 0);
    xfer(8'h01, 0, od, os, oz);
    check("h01_data", 32'(od), 32'h80);
    check("h01_shamt", 32'(os), 7);
    xfer(8'h00, 0, od, os, oz);
    check("h00_data", 32'(od), 0);
    check("h00_shamt", 32'(os), 0);
    check("h00_zero", 32'(oz), 1);

    // Backpressure: result must hold while out_ready is low.
    @(negedge clk);
    in_data  = 8'h0A;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!out_valid && cyc < 12);
    check("bp_latency", 32'(cyc), 4);
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 1);
      check("bp_data", 32'(out_data), 32'hA0);
      check("bp_shamt", 32'(out_shamt), 4);
      check("bp_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_consumed", 32'(out_valid), 0);
    check("bp_in_ready_next", 32'(in_ready), 1);

    // Busy rejection: in_valid stays high across two words.
    @(negedge clk);
    in_data  = 8'h01;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_data = 8'h40;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!out_valid && cyc < 12);
    check("busy1_latency", 32'(cyc), 4);
    check("busy1_data", 32'(out_data), 32'h80);
    check("busy1_shamt", 32'(out_shamt), 7);
    check("busy1_in_ready", 32'(in_ready), 0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("busy_idle_again", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("busy2_accepted", 32'(in_ready), 0);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!out_valid && cyc < 12);
    check("busy2_latency", 32'(cyc), 4);
    check("busy2_data", 32'(out_data), 32'h80);
    check("busy2_shamt", 32'(out_shamt), 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Mid-operation reset in the second SEARCH cycle.
    @(negedge clk);
    in_data  = 8'h05;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_in_ready", 32'(in_ready), 1);
    check("mrst_out_valid", 32'(out_valid), 0);
    check("mrst_out_data", 32'(out_data), 0);
    check("mrst_out_shamt", 32'(out_shamt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("mrst_no_valid", 32'(out_valid), 0);
    end
    xfer(8'h20, 0, od, os, oz);
    check("h20_data", 32'(od), 32'h80);
    check("h20_shamt", 32'(os), 2);

    // Exhaustive sweep with random consumer stalls.
    for (int i = 0; i < 256; i++) begin
      v = 8'(i);
      xfer(v, int'($urandom_range(0, 3)), od, os, oz);
      lz    = 0;
      found = 1'b0;
      for (int b = 7; b >= 0; b--) begin
        if (!found) begin
          if (v[b]) found = 1'b1;
          else lz++;
        end
      end
      if (v == 8'h00) begin
        check("sw_zero_flag", 32'(oz), 1);
        check("sw_zero_data", 32'(od), 0);
        check("sw_zero_shamt", 32'(os), 0);
      end else begin
        check("sw_flag", 32'(oz), 0);
        check("sw_shamt", 32'(os), 32'(lz));
        check("sw_shift", 32'(od), 32'(8'(v << os)));
        check("sw_msb", 32'(od[7]), 1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
